// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU operation sequencer.
//   - 4-bit Op_Alu result codes, R-type Funct codes, ALUOp codes
//   - FSM state encoding and iterative-engine op select
//   - iteration step counts and decode/classification helpers
package alu_pkg;

  // Op_Alu codes
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_RSQRT = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_INV   = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b1111;

  // R-type Funct codes
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_MUL   = 6'b011000;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_RSQRT = 6'b111000;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  // Iteration counts of the multi-cycle engines
  localparam logic [5:0] MUL_STEPS   = 6'd32;
  localparam logic [5:0] DIV_STEPS   = 6'd32;
  localparam logic [5:0] SQRT_STEPS  = 6'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ONE  = 2'b01,
    ST_ITER = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ITER_MUL  = 2'b00,
    ITER_DIV  = 2'b01,
    ITER_SQRT = 2'b10
  } iter_op_e;

  // ALUOp/Funct -> Op_Alu; anything not in the table decodes as invalid
  function automatic logic [3:0] decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
    logic [3:0] code;
    code = OP_INV;
    case (alu_op)
      ALUOP_ADD: code = OP_ADD;
      ALUOP_SUB: code = OP_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:   code = OP_ADD;
          FN_SUB:   code = OP_SUB;
          FN_AND:   code = OP_AND;
          FN_OR:    code = OP_OR;
          FN_SLT:   code = OP_SLT;
          FN_SLL:   code = OP_SLL;
          FN_MUL:   code = OP_MUL;
          FN_DIVU:  code = OP_DIVU;
          FN_RSQRT: code = OP_RSQRT;
          default:  code = OP_INV;
        endcase
      end
      default: code = OP_INV;
    endcase
    return code;
  endfunction

  function automatic logic is_iter_op(input logic [3:0] code);
    logic iter;
    case (code)
      OP_MUL, OP_DIVU, OP_RSQRT: iter = 1'b1;
      default:                   iter = 1'b0;
    endcase
    return iter;
  endfunction

  function automatic iter_op_e iter_sel(input logic [3:0] code);
    iter_op_e sel;
    case (code)
      OP_DIVU:  sel = ITER_DIV;
      OP_RSQRT: sel = ITER_SQRT;
      default:  sel = ITER_MUL;
    endcase
    return sel;
  endfunction

  function automatic logic [5:0] iter_steps(input logic [3:0] code);
    logic [5:0] steps;
    case (code)
      OP_MUL:   steps = MUL_STEPS;
      OP_DIVU:  steps = DIV_STEPS;
      OP_RSQRT: steps = SQRT_STEPS;
      default:  steps = 6'd0;
    endcase
    return steps;
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: shared iterative datapath for MUL (shift-add), DIVU
// (restoring, remainder) and RSQRT (digit-by-digit integer square root).
// Ports:
//   clk     in  1  clock, rising edge
//   rst     in  1  synchronous active-high reset
//   load    in  1  capture operands and op select, clear accumulator
//   step    in  1  advance one iteration
//   op_sel  in  2  engine select, sampled on load
//   op_a    in  W  first operand (multiplicand / dividend / radicand)
//   op_b    in  W  second operand (multiplier / divisor; unused by RSQRT)
//   result  out W  current engine result (product / remainder / root)
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  iter_op_e     op_sel,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic [W-1:0] result
);

  // Register roles per engine:
  //   MUL : acc = partial product, a = shifted multiplicand, b = shifted multiplier
  //   DIV : acc = partial remainder, a = dividend shifting out MSB first, b = divisor
  //   SQRT: acc = partial remainder, a = radicand shifting out 2 bits per step, b = root
  iter_op_e     op_r;
  logic [W-1:0] acc_r;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;

  logic [W-1:0] acc_nxt_s;
  logic [W-1:0] a_nxt_s;
  logic [W-1:0] b_nxt_s;
  logic [W:0]   div_trial_s;
  logic [W-1:0] sq_rem_s;
  logic [W-1:0] sq_trial_s;

  // One iteration of the selected engine
  always_comb begin
    acc_nxt_s   = acc_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    div_trial_s = {acc_r, a_r[W-1]};
    sq_rem_s    = {acc_r[W-3:0], a_r[W-1:W-2]};
    sq_trial_s  = {b_r[W-3:0], 2'b01};
    case (op_r)
      ITER_MUL: begin
        if (b_r[0]) begin
          acc_nxt_s = acc_r + a_r;
        end else begin
          acc_nxt_s = acc_r;
        end
        a_nxt_s = {a_r[W-2:0], 1'b0};
        b_nxt_s = {1'b0, b_r[W-1:1]};
      end
      ITER_DIV: begin
        // Trial fits in W+1 bits; when it fits the divisor the true
        // difference is below 2^W, so a W-bit subtract is exact.
        if (div_trial_s >= {1'b0, b_r}) begin
          acc_nxt_s = div_trial_s[W-1:0] - b_r;
        end else begin
          acc_nxt_s = div_trial_s[W-1:0];
        end
        a_nxt_s = {a_r[W-2:0], 1'b0};
        b_nxt_s = b_r;
      end
      ITER_SQRT: begin
        // Bring down the next radicand bit pair and try root digit 1.
        if (sq_rem_s >= sq_trial_s) begin
          acc_nxt_s = sq_rem_s - sq_trial_s;
          b_nxt_s   = {b_r[W-2:0], 1'b1};
        end else begin
          acc_nxt_s = sq_rem_s;
          b_nxt_s   = {b_r[W-2:0], 1'b0};
        end
        a_nxt_s = {a_r[W-3:0], 2'b00};
      end
      default: begin
        acc_nxt_s = acc_r;
        a_nxt_s   = a_r;
        b_nxt_s   = b_r;
      end
    endcase
  end

  // Engine state: load operands, then step once per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r  <= ITER_MUL;
      acc_r <= {W{1'b0}};
      a_r   <= {W{1'b0}};
      b_r   <= {W{1'b0}};
    end else if (load) begin
      op_r  <= op_sel;
      acc_r <= {W{1'b0}};
      a_r   <= op_a;
      b_r   <= (op_sel == ITER_SQRT) ? {W{1'b0}} : op_b;
    end else if (step) begin
      op_r  <= op_r;
      acc_r <= acc_nxt_s;
      a_r   <= a_nxt_s;
      b_r   <= b_nxt_s;
    end else begin
      op_r  <= op_r;
      acc_r <= acc_r;
      a_r   <= a_r;
      b_r   <= b_r;
    end
  end

  assign result = (op_r == ITER_SQRT) ? b_r : acc_r;

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes ALUOp/Funct into Op_Alu and executes the op.
// Single-cycle ops finish two cycles after start; MUL/DIVU/RSQRT run on the
// iterative core behind a start/busy/done handshake.
// Ports:
//   clk     in  1  clock, rising edge
//   rst     in  1  synchronous active-high reset (aborts any op, no done)
//   start   in  1  request, sampled only when not busy (IDLE or DONE)
//   ALUOp   in  2  00 add, 01 sub, 10 R-type, 11 reserved
//   Funct   in  6  R-type function field
//   Op_1    in  W  first operand, latched on accepted start
//   Op_2    in  W  second operand, latched on accepted start
//   Op_Alu  out 4  decoded code of the accepted op
//   busy    out 1  high from the cycle after acceptance until done
//   done    out 1  one-cycle completion pulse
//   Res     out W  result, held until the next completion
//   ZF      out 1  Res == 0, updated with Res
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int W        = 32,
  parameter int SQRT_MAX = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   ALUOp,
  input  logic [5:0]   Funct,
  input  logic [W-1:0] Op_1,
  input  logic [W-1:0] Op_2,
  output logic [3:0]   Op_Alu,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Res,
  output logic         ZF
);

  localparam logic [W-1:0] SQRT_MAX_W = W'(SQRT_MAX);

  state_e       state_r;
  logic [5:0]   cnt_r;
  logic [3:0]   op_alu_r;
  logic [W-1:0] opa_r;
  logic [W-1:0] opb_r;
  logic         busy_r;
  logic         done_r;
  logic [W-1:0] res_r;
  logic         zf_r;

  logic [3:0]   dec_s;
  logic         accept_s;
  logic         load_s;
  logic         step_s;
  logic [W-1:0] single_s;
  logic [W-1:0] core_res_s;
  logic [W-1:0] final_s;

  assign dec_s    = decode_op(ALUOp, Funct);
  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign load_s   = accept_s && is_iter_op(dec_s);
  // The last ITER cycle only captures the result; it does not step.
  assign step_s   = (state_r == ST_ITER) && (cnt_r != iter_steps(op_alu_r));

  alu_iter_core #(.W(W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .step   (step_s),
    .op_sel (iter_sel(dec_s)),
    .op_a   (Op_1),
    .op_b   (Op_2),
    .result (core_res_s)
  );

  // Single-cycle results from the latched operands
  always_comb begin
    single_s = {W{1'b0}};
    case (op_alu_r)
      OP_ADD:  single_s = opa_r + opb_r;
      OP_SUB:  single_s = opa_r - opb_r;
      OP_AND:  single_s = opa_r & opb_r;
      OP_OR:   single_s = opa_r | opb_r;
      OP_SLT:  single_s = {{(W-1){1'b0}}, (opa_r < opb_r)};
      OP_SLL:  single_s = {opb_r[W-2:0], 1'b0};
      default: single_s = {W{1'b0}};
    endcase
  end

  // Final iterative result with the divide-by-zero and sqrt-range rules
  always_comb begin
    final_s = {W{1'b0}};
    case (op_alu_r)
      OP_MUL: final_s = core_res_s;
      OP_DIVU: begin
        if (opb_r == {W{1'b0}}) begin
          final_s = opa_r;
        end else begin
          final_s = core_res_s;
        end
      end
      OP_RSQRT: begin
        if ((opa_r == {W{1'b0}}) || (opa_r > SQRT_MAX_W)) begin
          final_s = {W{1'b0}};
        end else begin
          final_s = core_res_s;
        end
      end
      default: final_s = {W{1'b0}};
    endcase
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 6'd0;
      op_alu_r <= 4'b0000;
      opa_r    <= {W{1'b0}};
      opb_r    <= {W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      res_r    <= {W{1'b0}};
      zf_r     <= 1'b0;
    end else begin
      case (state_r)
        // DONE accepts a new start exactly like IDLE for back-to-back ops
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            opa_r    <= Op_1;
            opb_r    <= Op_2;
            op_alu_r <= dec_s;
            cnt_r    <= 6'd0;
            busy_r   <= 1'b1;
            state_r  <= is_iter_op(dec_s) ? ST_ITER : ST_ONE;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_ONE: begin
          res_r   <= single_s;
          zf_r    <= (single_s == {W{1'b0}});
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_DONE;
        end
        ST_ITER: begin
          if (cnt_r == iter_steps(op_alu_r)) begin
            res_r   <= final_s;
            zf_r    <= (final_s == {W{1'b0}});
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Op_Alu = op_alu_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign Res    = res_r;
  assign ZF     = zf_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed cases plus randomized
// transactions, checked every cycle against a behavioural model.
module tb_alu_op_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   ALUOp = 2'b00;
  logic [5:0]   Funct = 6'b000000;
  logic [W-1:0] Op_1 = 32'd0;
  logic [W-1:0] Op_2 = 32'd0;
  logic [3:0]   Op_Alu;
  logic         busy;
  logic         done;
  logic [W-1:0] Res;
  logic         ZF;

  alu_op_sequencer #(.W(W), .SQRT_MAX(100)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ALUOp  (ALUOp),
    .Funct  (Funct),
    .Op_1   (Op_1),
    .Op_2   (Op_2),
    .Op_Alu (Op_Alu),
    .busy   (busy),
    .done   (done),
    .Res    (Res),
    .ZF     (ZF)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Current transaction (written by the driver only)
  int          p_t = -1;
  int          p_done = -1;
  logic [3:0]  p_code = 4'd0;
  logic [31:0] p_res = 32'd0;
  int          lit_cyc = -1;
  logic [31:0] lit_exp = 32'd0;

  // Comparison counters (written by the checker only)
  int n_checks = 0;
  int n_pass = 0;

  logic [5:0] fn_tab [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                             6'b000000, 6'b011000, 6'b011011, 6'b111000};
  logic [3:0] cd_tab [9] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd15, 4'd3, 4'd4, 4'd5};

  // Behavioural model: code, result and start-to-done latency
  function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [3:0] code, output logic [31:0] res,
                                output int lat);
    code = 4'd8;
    if (op == 2'b00) code = 4'd2;
    else if (op == 2'b01) code = 4'd6;
    else if (op == 2'b10) begin
      for (int i = 0; i < 9; i++) if (fn_tab[i] == fn) code = cd_tab[i];
    end
    case (code)
      4'd2:    res = a + b;
      4'd6:    res = a - b;
      4'd0:    res = a & b;
      4'd1:    res = a | b;
      4'd7:    res = (a < b) ? 32'd1 : 32'd0;
      4'd15:   res = b << 1;
      4'd3:    res = a * b;
      4'd4:    res = (b == 32'd0) ? a : (a % b);
      4'd5: begin
        res = 32'd0;
        if (a != 32'd0 && a <= 32'd100)
          for (int r = 0; r <= 11; r++) if (r * r <= int'(a)) res = r;
      end
      default: res = 32'd0;
    endcase
    lat = (code == 4'd3 || code == 4'd4) ? 34 : (code == 4'd5) ? 18 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Per-cycle compare process
  initial begin
    logic [31:0] held_res;
    logic        held_zf;
    logic [3:0]  held_code;
    held_res = 32'd0; held_zf = 1'b0; held_code = 4'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_res = 32'd0; held_zf = 1'b0; held_code = 4'd0;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res", Res, 32'd0);
        chk("rst_zf", 32'(ZF), 32'd0);
        chk("rst_op_alu", 32'(Op_Alu), 32'd0);
      end else if (cyc == p_done) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_res", Res, p_res);
        chk("done_zf", 32'(ZF), 32'(p_res == 32'd0));
        chk("done_op_alu", 32'(Op_Alu), 32'(p_code));
        if (lit_cyc == p_done) chk("literal_res", Res, lit_exp);
        held_res = p_res; held_zf = (p_res == 32'd0); held_code = p_code;
      end else if (cyc > p_t && cyc < p_done) begin
        chk("busy_done", 32'(done), 32'd0);
        chk("busy_busy", 32'(busy), 32'd1);
        chk("busy_res_held", Res, held_res);
        chk("busy_zf_held", 32'(ZF), 32'(held_zf));
        chk("busy_op_alu", 32'(Op_Alu), 32'(p_code));
      end else begin
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_res", Res, held_res);
        chk("idle_zf", 32'(ZF), 32'(held_zf));
        chk("idle_op_alu", 32'(Op_Alu), 32'(held_code));
      end
    end
  end

  // Present a start this cycle (DUT must be in IDLE or DONE)
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input bit has_lit, input logic [31:0] lit);
    logic [3:0]  code;
    logic [31:0] r;
    int          lat;
    model(op, fn, a, b, code, r, lat);
    start = 1'b1; ALUOp = op; Funct = fn; Op_1 = a; Op_2 = b;
    p_t = cyc; p_done = cyc + lat; p_code = code; p_res = r;
    lit_cyc = has_lit ? p_done : -1;
    lit_exp = lit;
  endtask

  // Advance to the done cycle; optionally hammer start while busy
  task automatic wait_done(input bit junk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (cyc >= p_done) break;
      if (junk) begin
        start = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        ALUOp = 2'($urandom); Funct = 6'($urandom);
        Op_1 = $urandom; Op_2 = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic idle1();
    @(negedge clk); #1;
  endtask

  initial begin
    int sel;
    int gap;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    idle1();

    // Single-cycle ops
    issue(2'b10, 6'b100000, 32'd5, 32'd7, 1'b1, 32'd12); wait_done(1'b0); idle1();
    issue(2'b10, 6'b100010, 32'd9, 32'd9, 1'b1, 32'd0); wait_done(1'b0); idle1();
    issue(2'b10, 6'b101010, 32'd3, 32'd5, 1'b1, 32'd1); wait_done(1'b0); idle1();
    issue(2'b10, 6'b000000, 32'd1, 32'h8000_0000, 1'b1, 32'd0); wait_done(1'b0); idle1();
    issue(2'b11, 6'b100000, 32'd4, 32'd4, 1'b1, 32'd0); wait_done(1'b0); idle1();

    // MUL with ignored starts during busy
    issue(2'b10, 6'b011000, 32'h0000_FFFF, 32'h0001_0001, 1'b1, 32'hFFFF_FFFF);
    wait_done(1'b1); idle1();

    // DIVU remainder and divide by zero
    issue(2'b10, 6'b011011, 32'd100, 32'd7, 1'b1, 32'd2); wait_done(1'b0); idle1();
    issue(2'b10, 6'b011011, 32'd5, 32'd0, 1'b1, 32'd5); wait_done(1'b0); idle1();

    // RSQRT around the valid range edges
    issue(2'b10, 6'b111000, 32'd99, 32'd0, 1'b1, 32'd9); wait_done(1'b0); idle1();
    issue(2'b10, 6'b111000, 32'd100, 32'd0, 1'b1, 32'd10); wait_done(1'b0); idle1();
    issue(2'b10, 6'b111000, 32'd101, 32'd0, 1'b1, 32'd0); wait_done(1'b0); idle1();
    issue(2'b10, 6'b111000, 32'd0, 32'd0, 1'b1, 32'd0); wait_done(1'b0); idle1();

    // Reset in the middle of a MUL aborts with no done pulse
    issue(2'b10, 6'b011000, 32'd3, 32'd4, 1'b0, 32'd0);
    repeat (10) begin @(negedge clk); #1; start = 1'b0; end
    rst = 1'b1; p_t = -1; p_done = -1; lit_cyc = -1;
    idle1();
    rst = 1'b0;
    idle1();

    // Back-to-back start in the DONE cycle
    issue(2'b00, 6'b000000, 32'd1, 32'd2, 1'b1, 32'd3); wait_done(1'b0);
    issue(2'b01, 6'b000000, 32'd20, 32'd3, 1'b1, 32'd17); wait_done(1'b0);
    issue(2'b10, 6'b011011, 32'd1000, 32'd33, 1'b1, 32'd10); wait_done(1'b0); idle1();

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 11);
      a = $urandom; b = $urandom;
      if (sel < 9) begin
        op = 2'b10; fn = fn_tab[sel];
        if (sel == 8) a = $urandom_range(0, 130);
        if (sel == 7 && $urandom_range(0, 3) == 0) b = 32'd0;
        if (sel < 2 && $urandom_range(0, 3) == 0) b = a;
      end else if (sel == 9) begin
        op = 2'b00; fn = 6'($urandom);
      end else if (sel == 10) begin
        op = 2'b01; fn = 6'($urandom);
      end else begin
        op = 2'($urandom_range(2, 3)); fn = 6'($urandom);
      end
      issue(op, fn, a, b, 1'b0, 32'd0);
      wait_done(1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      repeat (gap) idle1();
    end
    idle1();
    idle1();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
